serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 111 +++++++++++
 tb/tb_serial_subtractor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock; result and flags held until the next completion.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_next;
  logic             bin_q;
  logic             d_bit, bout_bit;
  logic             last_bit;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, b_msb_q;
`endif

  full_subtractor u_fs (
    .x   (a_q[0]),
    .y   (b_q[0]),
    .bin (bin_q),
    .d   (d_bit),
    .bout(bout_bit)
  );

  assign last_bit = (cnt_q == CntW'(WIDTH - 1));
  // New difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  assign res_next = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      bin_q   <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            res_q <= '0;
            cnt_q <= '0;
            bin_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          bin_q <= bout_bit;
          res_q <= res_next;
          cnt_q <= cnt_q + CntW'(1);
          if (last_bit) begin
            diff   <= res_next;
            borrow <= bout_bit;
`ifdef SERIAL_SUB_OVF_EN
            // d_bit here is the result MSB.
            ovf <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1 instances).
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, borrow;
  logic [7:0] diff;
  logic       start1;
  logic [0:0] a1, b1, diff1;
  logic       busy1, done1, borrow1;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf, ovf1;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .borrow(borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .diff  (diff1),
    .borrow(borrow1)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start at edge 0, expect done in cycle 9 and idle in cycle 10.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ed,
                        input logic eb, input logic eo, input string tag);
    logic [7:0] prev_diff;
    logic       prev_borrow;
    logic       mid_ok;
    prev_diff   = diff;
    prev_borrow = borrow;
    mid_ok      = 1'b1;
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    chk(busy, 1, {tag, "_busy_c1"});
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) tick();
      if (done !== 1'b0 || busy !== 1'b1 || diff !== prev_diff || borrow !== prev_borrow)
        mid_ok = 1'b0;
    end
    chk(mid_ok, 1, {tag, "_shift_quiet"});
    tick();
    chk(done, 1, {tag, "_done_c9"});
    chk(busy, 1, {tag, "_busy_c9"});
    chk(diff, ed, {tag, "_diff"});
    chk(borrow, eb, {tag, "_borrow"});
`ifdef SERIAL_SUB_OVF_EN
    chk(ovf, eo, {tag, "_ovf"});
`else
    if (eo === 1'bx) $display("unexpected x in expected ovf for %s", tag);
`endif
    tick();
    chk({busy, done}, 0, {tag, "_idle_c10"});
    chk(diff, ed, {tag, "_diff_held"});
  endtask

  initial begin
    logic seen_done;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    #12;
    chk({busy, done, borrow}, 0, "rst_flags");
    chk(diff, 0, "rst_diff");
    chk({busy1, done1}, 0, "rst_w1");
`ifdef SERIAL_SUB_OVF_EN
    chk(ovf, 0, "rst_ovf");
`endif
    tick();
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "sub_5_3");
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "sub_3_5");
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "sub_80_1");
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "sub_7f_ff");

    // Second start at cycle 3 must be ignored.
    a = 8'h10; b = 8'h04; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk(done, 0, "ign_c8");
    tick();
    chk(done, 1, "ign_done_c9");
    chk(diff, 8'h0C, "ign_diff");
    tick();
    chk(busy, 0, "ign_idle");

    // Continuous start: one idle cycle between operations.
    a = 8'h20; b = 8'h01; start = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    chk(done, 1, "cont_done1");
    chk(diff, 8'h1F, "cont_diff1");
    a = 8'h01; b = 8'h02;
    tick();
    chk({busy, done}, 0, "cont_gap");
    tick();
    chk(busy, 1, "cont_restart");
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk(done, 1, "cont_done2");
    chk(diff, 8'hFF, "cont_diff2");
    chk(borrow, 1, "cont_borrow2");
    tick();

    // Reset in cycle 4 of an operation.
    a = 8'h44; b = 8'h11; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    #1;
    chk({busy, done, borrow}, 0, "mid_rst_flags");
    chk(diff, 0, "mid_rst_diff");
    #1;
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
    end
    chk(seen_done, 0, "mid_rst_no_done");
    run_op(8'h44, 8'h11, 8'h33, 1'b0, 1'b0, "post_rst");

    // WIDTH=1: 0 - 1.
    a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk({busy1, done1}, 2'b10, "w1_c1");
    tick();
    chk(done1, 1, "w1_done_c2");
    chk(diff1, 1, "w1_diff");
    chk(borrow1, 1, "w1_borrow");
`ifdef SERIAL_SUB_OVF_EN
    chk(ovf1, 1, "w1_ovf");
`endif
    tick();
    chk({busy1, done1}, 0, "w1_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
